trig_capture: RTL

- Capture-side counterpart to the signal generator's address counter: instead of stepping an address to read waveform samples out, it steps a write address to store incoming samples in a circular buffer.
- Runs an armed trigger state machine that keeps a fixed pre-trigger history, detects a rising level crossing, then records post-trigger samples.
- Frozen buffer is read back oldest-first through a registered read port, for display or for checking the generator output in loopback.

---
 rtl/trig_capture_pkg.sv | 17 +
 rtl/capture_ram.sv | 30 +++
 rtl/trig_capture.sv | 133 +++++++++++++
 3 files changed

// File: rtl/trig_capture_pkg.sv
// Shared types and helpers for the triggered capture block.
package trig_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } state_t;

  // Post-trigger writes that fill the ring exactly once around the trigger sample.
  function automatic int post_len(input int a_width, input int pre_trig);
    return (1 << a_width) - pre_trig - 1;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module capture_ram #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];
  logic [D_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read sees the pre-write contents when addresses collide.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trig_capture.sv
// Armed trigger capture into a circular buffer with oldest-first readback.
//   state | meaning
//   IDLE  | waiting for arm, no writes
//   PRE   | filling PRE_TRIG history samples
//   WAIT  | writing continuously, looking for a rising crossing
//   POST  | recording post-trigger samples
//   DONE  | buffer frozen, readback valid
module trig_capture
  import trig_capture_pkg::*;
#(
  parameter int A_WIDTH  = 8,
  parameter int D_WIDTH  = 8,
  parameter int PRE_TRIG = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm_i,
  input  logic               sample_en_i,
  input  logic [D_WIDTH-1:0] sample_i,
  input  logic [D_WIDTH-1:0] trig_level_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [A_WIDTH-1:0] trig_addr_o
);

  localparam logic [A_WIDTH-1:0] PRE_TC  = A_WIDTH'(PRE_TRIG);
  localparam logic [A_WIDTH-1:0] POST_TC = A_WIDTH'(post_len(A_WIDTH, PRE_TRIG));
  localparam logic [A_WIDTH-1:0] ONE     = A_WIDTH'(1);

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] wp_q, wp_d;
  logic [A_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [A_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic [D_WIDTH-1:0] prev_q, prev_d;
  logic [A_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [A_WIDTH-1:0] pre_inc, post_inc, rd_ptr;
  logic               we, trig_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      prev_q      <= '0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      prev_q      <= prev_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  assign pre_inc  = pre_cnt_q + ONE;
  assign post_inc = post_cnt_q + ONE;
  assign trig_hit = (prev_q < trig_level_i) && (sample_i >= trig_level_i);

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    prev_d      = prev_q;
    trig_addr_d = trig_addr_q;
    we          = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          state_d   = ST_PRE;
          wp_d      = '0;
          pre_cnt_d = '0;
        end
      end
      ST_PRE: begin
        if (sample_en_i) begin
          we        = 1'b1;
          pre_cnt_d = pre_inc;
          if (pre_inc == PRE_TC) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sample_en_i) begin
          we = 1'b1;
          if (trig_hit) begin
            trig_addr_d = wp_q;
            post_cnt_d  = '0;
            state_d     = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (sample_en_i) begin
          we         = 1'b1;
          post_cnt_d = post_inc;
          if (post_inc == POST_TC) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (we) begin
      wp_d   = wp_q + ONE;
      prev_d = sample_i;
    end
  end

  always_comb begin
    busy_o = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
    done_o = (state_q == ST_DONE);
  end

  // Oldest retained sample sits PRE_TRIG slots before the trigger.
  assign rd_ptr      = trig_addr_q - PRE_TC + rd_addr_i;
  assign trig_addr_o = trig_addr_q;

  capture_ram #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we & ~rst),
    .waddr_i (wp_q),
    .wdata_i (sample_i),
    .raddr_i (rd_ptr),
    .rdata_o (rd_data_o)
  );

endmodule
